mem_lsu: RTL and testbench

Load/store unit forming the memory-access stage directly after the execute stage. It consumes the execute stage's operation code, read/write addresses, store data and ALU write-back value, and runs the data-memory bus transaction with a request/grant/response handshake. It performs byte-lane steering for stores and lane select plus sign/zero extension for loads. It stalls the upstream pipeline while a transaction is outstanding and delivers the final register write-back word.

---
 rtl/mem_lsu_pkg.sv | 67 ++++++
 rtl/lsu_load_align.sv | 28 ++
 rtl/mem_lsu.sv | 197 +++++++++++++++++++
 tb/tb_mem_lsu.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared opcode and LSU type definitions for the memory-access stage.
// opcode_pkg holds the execute-stage op encoding; type_pkg holds bus widths and LSU payloads.
package opcode_pkg;

    typedef enum logic [4:0] {
        EX_NOP, EX_ADD, EX_SUB, EX_AND, EX_OR, EX_XOR, EX_SLL, EX_SRL,
        EX_SRA, EX_SLT, EX_SLTU, EX_LUI, EX_AUIPC, EX_BEQ, EX_BNE, EX_BLT,
        EX_BGE, EX_BLTU, EX_BGEU, EX_JAL, EX_JALR,
        EX_LB, EX_LH, EX_LW, EX_LBU, EX_LHU,
        EX_SB, EX_SH, EX_SW
    } ExCode;

    function automatic logic is_load(ExCode op);
        return op inside {EX_LB, EX_LH, EX_LW, EX_LBU, EX_LHU};
    endfunction

    function automatic logic is_store(ExCode op);
        return op inside {EX_SB, EX_SH, EX_SW};
    endfunction

    // Byte accesses can never be misaligned; halves need bit 0 clear, words need [1:0] clear.
    function automatic logic is_misaligned(ExCode op, logic [1:0] off);
        if (op inside {EX_LH, EX_LHU, EX_SH}) begin
            return off[0];
        end else if (op inside {EX_LW, EX_SW}) begin
            return off != 2'b00;
        end
        return 1'b0;
    endfunction

endpackage

package type_pkg;

    localparam int unsigned RegBusW     = 32;
    localparam int unsigned MemBusW     = 32;
    localparam int unsigned MemAddrBusW = 32;
    localparam int unsigned RegAddrW    = 5;
    localparam int unsigned BeW         = 4;
    localparam int unsigned OffW        = 2;

    typedef logic [RegBusW-1:0]     RegBus;
    typedef logic [MemBusW-1:0]     MemBus;
    typedef logic [MemAddrBusW-1:0] MemAddrBus;
    typedef logic [OffW-1:0]        ByteOff;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_RESP
    } LsuState;

    typedef struct packed {
        logic            we;
        MemAddrBus       addr;
        logic [BeW-1:0]  be;
        MemBus           wdata;
    } bus_req_t;

    typedef struct packed {
        logic                we;
        logic [RegAddrW-1:0] rd;
        RegBus               wdata;
        logic                misalign;
    } wb_beat_t;

endpackage

// File: rtl/lsu_load_align.sv
// Load lane select and sign/zero extension from a raw bus word.
module lsu_load_align
    import opcode_pkg::*;
    import type_pkg::*;
(
    input  logic [MemBusW-1:0] rdata_i,
    input  logic [OffW-1:0]    offset_i,
    input  ExCode              ex_code_i,
    output logic [RegBusW-1:0] ld_data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = rdata_i[{offset_i, 3'b000} +: 8];
        half_sel  = rdata_i[{offset_i[1], 4'b0000} +: 16];
        ld_data_c = rdata_i;
        case (ex_code_i)
            EX_LB:   ld_data_c = {{24{byte_sel[7]}}, byte_sel};
            EX_LBU:  ld_data_c = {24'h00_0000, byte_sel};
            EX_LH:   ld_data_c = {{16{half_sel[15]}}, half_sel};
            EX_LHU:  ld_data_c = {16'h0000, half_sel};
            default: ld_data_c = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access stage: runs the req/gnt/rvalid data bus transaction, steers store lanes,
// aligns load data and produces the single-cycle register write-back beat.
module mem_lsu
    import opcode_pkg::*;
    import type_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    input  ExCode                  ex_code_i,
    input  logic [MemAddrBusW-1:0] mem_raddr_i,
    input  logic [MemAddrBusW-1:0] mem_waddr_i,
    input  logic [MemBusW-1:0]     mem_wdata_i,
    input  logic [RegBusW-1:0]     reg_wdata_i,
    input  logic [RegAddrW-1:0]    rd_addr_i,
    input  logic                   rd_we_i,
    output logic                   stall_o,
    output logic                   req_o,
    output logic                   we_o,
    output logic [MemAddrBusW-1:0] addr_o,
    output logic [BeW-1:0]         be_o,
    output logic [MemBusW-1:0]     wdata_o,
    input  logic                   gnt_i,
    input  logic                   rvalid_i,
    input  logic [MemBusW-1:0]     rdata_i,
    output logic                   wb_valid_o,
    output logic                   wb_we_o,
    output logic [RegAddrW-1:0]    wb_rd_o,
    output logic [RegBusW-1:0]     wb_wdata_o,
    output logic                   misalign_o
);

    LsuState             state_q, state_d;
    ExCode               op_q, op_d;
    ByteOff              off_q, off_d;
    logic [RegAddrW-1:0] rd_q, rd_d;
    logic                rd_we_q, rd_we_d;
    bus_req_t            bus_q, bus_d;
    logic                req_q, req_d;
    wb_beat_t            wb_q, wb_d;
    logic                wb_valid_q, wb_valid_d;

    logic                acc_load;
    logic                acc_store;
    logic                acc_mis;
    MemAddrBus           acc_addr;
    ByteOff              acc_off;
    logic [BeW-1:0]      st_be;
    MemBus               st_wdata;
    RegBus               ld_data_c;

    // Decode of the op presented by execute this cycle.
    always_comb begin
        acc_load  = is_load(ex_code_i);
        acc_store = is_store(ex_code_i);
        acc_addr  = acc_load ? mem_raddr_i : mem_waddr_i;
        acc_off   = acc_addr[1:0];
        acc_mis   = is_misaligned(ex_code_i, acc_off);
    end

    // Store byte-lane steering; loads request the full word.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = '0;
        case (ex_code_i)
            EX_SB: begin
                st_be    = 4'(4'b0001 << acc_off);
                st_wdata = {4{mem_wdata_i[7:0]}};
            end
            EX_SH: begin
                st_be    = acc_off[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{mem_wdata_i[15:0]}};
            end
            EX_SW: begin
                st_be    = 4'b1111;
                st_wdata = mem_wdata_i;
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = '0;
            end
        endcase
    end

    lsu_load_align u_load_align (
        .rdata_i   (rdata_i),
        .offset_i  (off_q),
        .ex_code_i (op_q),
        .ld_data_c (ld_data_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        off_d      = off_q;
        rd_d       = rd_q;
        rd_we_d    = rd_we_q;
        bus_d      = bus_q;
        req_d      = req_q;
        wb_d       = '0;
        wb_valid_d = 1'b0;

        case (state_q)
            LSU_IDLE: begin
                if (valid_i) begin
                    op_d    = ex_code_i;
                    off_d   = acc_off;
                    rd_d    = rd_addr_i;
                    rd_we_d = rd_we_i;
                    if (!(acc_load || acc_store)) begin
                        wb_valid_d = 1'b1;
                        wb_d.we    = rd_we_i;
                        wb_d.rd    = rd_addr_i;
                        wb_d.wdata = reg_wdata_i;
                    end else if (acc_mis) begin
                        wb_valid_d    = 1'b1;
                        wb_d.rd       = rd_addr_i;
                        wb_d.misalign = 1'b1;
                    end else begin
                        state_d     = LSU_REQ;
                        req_d       = 1'b1;
                        bus_d.we    = acc_store;
                        bus_d.addr  = {acc_addr[MemAddrBusW-1:2], 2'b00};
                        bus_d.be    = st_be;
                        bus_d.wdata = st_wdata;
                    end
                end
            end
            LSU_REQ: begin
                if (gnt_i) begin
                    req_d = 1'b0;
                    bus_d = '0;
                    if (is_store(op_q)) begin
                        state_d    = LSU_IDLE;
                        wb_valid_d = 1'b1;
                        wb_d.rd    = rd_q;
                    end else begin
                        state_d = LSU_RESP;
                    end
                end
            end
            LSU_RESP: begin
                if (rvalid_i) begin
                    state_d    = LSU_IDLE;
                    wb_valid_d = 1'b1;
                    wb_d.we    = rd_we_q;
                    wb_d.rd    = rd_q;
                    wb_d.wdata = ld_data_c;
                end
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LSU_IDLE;
            op_q       <= EX_NOP;
            off_q      <= '0;
            rd_q       <= '0;
            rd_we_q    <= 1'b0;
            bus_q      <= '0;
            req_q      <= 1'b0;
            wb_q       <= '0;
            wb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            off_q      <= off_d;
            rd_q       <= rd_d;
            rd_we_q    <= rd_we_d;
            bus_q      <= bus_d;
            req_q      <= req_d;
            wb_q       <= wb_d;
            wb_valid_q <= wb_valid_d;
        end
    end

    // Stall must be combinational so the accepting cycle already holds upstream.
    assign stall_o = !rst && ((state_q != LSU_IDLE) ||
                              (valid_i && (acc_load || acc_store) && !acc_mis));

    assign req_o      = req_q;
    assign we_o       = bus_q.we;
    assign addr_o     = bus_q.addr;
    assign be_o       = bus_q.be;
    assign wdata_o    = bus_q.wdata;
    assign wb_valid_o = wb_valid_q;
    assign wb_we_o    = wb_q.we;
    assign wb_rd_o    = wb_q.rd;
    assign wb_wdata_o = wb_q.wdata;
    assign misalign_o = wb_q.misalign;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: directed ops push expected bus requests and write-back beats,
// a negedge monitor pops and compares them whenever the DUT presents req_o or wb_valid_o.
module tb_mem_lsu;
    import opcode_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    ExCode       ex_code_i;
    logic [31:0] mem_raddr_i, mem_waddr_i, mem_wdata_i, reg_wdata_i;
    logic [4:0]  rd_addr_i;
    logic        rd_we_i;
    logic        stall_o, req_o, we_o;
    logic [31:0] addr_o, wdata_o;
    logic [3:0]  be_o;
    logic        gnt_i, rvalid_i;
    logic [31:0] rdata_i;
    logic        wb_valid_o, wb_we_o, misalign_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_wdata_o;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_lanes;
    } exp_bus_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        misalign;
        logic        chk_data;
    } exp_wb_t;

    exp_bus_t bus_q[$];
    exp_wb_t  wb_q[$];
    int vectors = 0;
    int miscompares = 0;

    mem_lsu dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ex_code_i(ex_code_i),
        .mem_raddr_i(mem_raddr_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
        .reg_wdata_i(reg_wdata_i), .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i),
        .stall_o(stall_o), .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .be_o(be_o),
        .wdata_o(wdata_o), .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
        .wb_valid_o(wb_valid_o), .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o),
        .wb_wdata_o(wb_wdata_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the head of the scoreboards.
    always @(negedge clk) begin
        if (!rst) begin
            if (req_o) begin
                if (bus_q.size() == 0) begin
                    chk("unexpected_req", 64'(req_o), 64'(0));
                end else begin
                    chk("bus_we", 64'(we_o), 64'(bus_q[0].we));
                    chk("bus_addr", 64'(addr_o), 64'(bus_q[0].addr));
                    if (bus_q[0].chk_lanes) begin
                        chk("bus_be", 64'(be_o), 64'(bus_q[0].be));
                        chk("bus_wdata", 64'(wdata_o), 64'(bus_q[0].wdata));
                    end
                    if (gnt_i) void'(bus_q.pop_front());
                end
            end
            if (wb_valid_o) begin
                if (wb_q.size() == 0) begin
                    chk("unexpected_wb", 64'(wb_valid_o), 64'(0));
                end else begin
                    chk("wb_we", 64'(wb_we_o), 64'(wb_q[0].we));
                    chk("wb_rd", 64'(wb_rd_o), 64'(wb_q[0].rd));
                    chk("wb_misalign", 64'(misalign_o), 64'(wb_q[0].misalign));
                    if (wb_q[0].chk_data) chk("wb_wdata", 64'(wb_wdata_o), 64'(wb_q[0].wdata));
                    void'(wb_q.pop_front());
                end
            end else if (misalign_o) begin
                chk("stray_misalign", 64'(misalign_o), 64'(0));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input ExCode op, input logic [31:0] ra, input logic [31:0] wa,
                         input logic [31:0] wd, input logic [31:0] rw, input logic [4:0] rd,
                         input logic we);
        valid_i = 1'b1; ex_code_i = op; mem_raddr_i = ra; mem_waddr_i = wa;
        mem_wdata_i = wd; reg_wdata_i = rw; rd_addr_i = rd; rd_we_i = we;
    endtask

    task automatic accept_and_clear();
        step();
        valid_i = 1'b0; ex_code_i = EX_NOP; mem_raddr_i = '0; mem_waddr_i = '0;
        mem_wdata_i = '0; reg_wdata_i = '0; rd_addr_i = '0; rd_we_i = 1'b0;
    endtask

    // Ops finishing in IDLE: non-memory ops and misaligned accesses.
    task automatic run_direct(input ExCode op, input logic [31:0] ra, input logic [31:0] wa,
                              input logic [31:0] rw, input logic [4:0] rd, input logic we,
                              input exp_wb_t e);
        wb_q.push_back(e);
        drive(op, ra, wa, 32'h0, rw, rd, we);
        #1 chk("stall_direct", 64'(stall_o), 64'(0));
        accept_and_clear();
        @(negedge clk);
        chk("wb_latency1", 64'(wb_valid_o), 64'(1));
        step();
    endtask

    task automatic run_store(input ExCode op, input logic [31:0] wa, input logic [31:0] wd,
                             input logic [4:0] rd, input int gnt_delay, input exp_bus_t eb);
        exp_wb_t e;
        e = '{we: 1'b0, rd: rd, wdata: 32'h0, misalign: 1'b0, chk_data: 1'b0};
        bus_q.push_back(eb);
        wb_q.push_back(e);
        drive(op, 32'h0, wa, wd, 32'h0, rd, 1'b0);
        #1 chk("stall_accept", 64'(stall_o), 64'(1));
        accept_and_clear();
        chk("stall_req", 64'(stall_o), 64'(1));
        repeat (gnt_delay) step();
        gnt_i = 1'b1;
        step();
        gnt_i = 1'b0;
    endtask

    task automatic run_load(input ExCode op, input logic [31:0] ra, input logic [31:0] rdata,
                            input logic [4:0] rd, input int gnt_delay,
                            input logic [31:0] exp_data);
        exp_bus_t eb;
        exp_wb_t  e;
        eb = '{we: 1'b0, addr: {ra[31:2], 2'b00}, be: 4'h0, wdata: 32'h0, chk_lanes: 1'b0};
        e  = '{we: 1'b1, rd: rd, wdata: exp_data, misalign: 1'b0, chk_data: 1'b1};
        bus_q.push_back(eb);
        wb_q.push_back(e);
        drive(op, ra, 32'h0, 32'h0, 32'h0, rd, 1'b1);
        accept_and_clear();
        repeat (gnt_delay) step();
        gnt_i = 1'b1;
        step();
        gnt_i = 1'b0;
        chk("stall_resp", 64'(stall_o), 64'(1));
        rvalid_i = 1'b1;
        rdata_i  = rdata;
        step();
        rvalid_i = 1'b0;
        rdata_i  = '0;
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; ex_code_i = EX_NOP; mem_raddr_i = '0; mem_waddr_i = '0;
        mem_wdata_i = '0; reg_wdata_i = '0; rd_addr_i = '0; rd_we_i = 1'b0;
        gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 64'(req_o), 64'(0));
        chk("rst_bus", {31'h0, we_o, addr_o}, 64'(0));
        chk("rst_lanes", {28'h0, be_o, wdata_o}, 64'(0));
        chk("rst_stall", 64'(stall_o), 64'(0));
        chk("rst_wb", {25'h0, wb_valid_o, wb_we_o, wb_rd_o, wb_wdata_o}, 64'(0));
        chk("rst_misalign", 64'(misalign_o), 64'(0));
        step();
        rst = 1'b0;

        run_direct(EX_ADD, 32'h0, 32'h0, 32'h0000_0007, 5'd5, 1'b1,
                   '{we: 1'b1, rd: 5'd5, wdata: 32'h7, misalign: 1'b0, chk_data: 1'b1});
        run_direct(EX_BEQ, 32'h0, 32'h0, 32'h0000_0055, 5'd2, 1'b0,
                   '{we: 1'b0, rd: 5'd2, wdata: 32'h55, misalign: 1'b0, chk_data: 1'b1});

        run_store(EX_SB, 32'h0000_0102, 32'h0000_00A5, 5'd0, 0,
                  '{we: 1'b1, addr: 32'h100, be: 4'b0100, wdata: 32'hA5A5_A5A5, chk_lanes: 1'b1});
        run_store(EX_SH, 32'h0000_0202, 32'h0000_BEEF, 5'd0, 3,
                  '{we: 1'b1, addr: 32'h200, be: 4'b1100, wdata: 32'hBEEF_BEEF, chk_lanes: 1'b1});
        run_store(EX_SW, 32'h0000_0108, 32'hCAFE_F00D, 5'd0, 1,
                  '{we: 1'b1, addr: 32'h108, be: 4'b1111, wdata: 32'hCAFE_F00D, chk_lanes: 1'b1});
        run_store(EX_SB, 32'h0000_010C, 32'h1234_5677, 5'd0, 0,
                  '{we: 1'b1, addr: 32'h10C, be: 4'b0001, wdata: 32'h7777_7777, chk_lanes: 1'b1});
        run_store(EX_SH, 32'h0000_0300, 32'h0000_1234, 5'd0, 0,
                  '{we: 1'b1, addr: 32'h300, be: 4'b0011, wdata: 32'h1234_1234, chk_lanes: 1'b1});

        run_load(EX_LB,  32'h0000_0403, 32'h8000_0000, 5'd7,  0, 32'hFFFF_FF80);
        run_load(EX_LBU, 32'h0000_0403, 32'h8000_0000, 5'd8,  0, 32'h0000_0080);
        run_load(EX_LH,  32'h0000_0502, 32'h8001_0000, 5'd10, 1, 32'hFFFF_8001);
        run_load(EX_LHU, 32'h0000_0500, 32'h1234_F00D, 5'd11, 0, 32'h0000_F00D);
        run_load(EX_LW,  32'h0000_0504, 32'hDEAD_BEEF, 5'd12, 2, 32'hDEAD_BEEF);
        run_load(EX_LB,  32'h0000_0601, 32'h0000_7F00, 5'd13, 0, 32'h0000_007F);

        run_direct(EX_LW, 32'h0000_0006, 32'h0, 32'h0, 5'd3, 1'b1,
                   '{we: 1'b0, rd: 5'd3, wdata: 32'h0, misalign: 1'b1, chk_data: 1'b0});
        run_direct(EX_LH, 32'h0000_0201, 32'h0, 32'h0, 5'd4, 1'b1,
                   '{we: 1'b0, rd: 5'd4, wdata: 32'h0, misalign: 1'b1, chk_data: 1'b0});
        run_direct(EX_SW, 32'h0, 32'h0000_0102, 32'h0, 5'd0, 1'b0,
                   '{we: 1'b0, rd: 5'd0, wdata: 32'h0, misalign: 1'b1, chk_data: 1'b0});

        // rvalid while idle must be ignored.
        rvalid_i = 1'b1; rdata_i = 32'hFFFF_FFFF;
        step();
        rvalid_i = 1'b0; rdata_i = '0;

        // Reset while a granted load waits for its response; the late rvalid is dropped.
        bus_q.push_back('{we: 1'b0, addr: 32'h700, be: 4'h0, wdata: 32'h0, chk_lanes: 1'b0});
        drive(EX_LW, 32'h0000_0700, 32'h0, 32'h0, 32'h0, 5'd9, 1'b1);
        accept_and_clear();
        gnt_i = 1'b1;
        step();
        gnt_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_req", 64'(req_o), 64'(0));
        chk("mid_rst_stall", 64'(stall_o), 64'(0));
        chk("mid_rst_wb", {25'h0, wb_valid_o, wb_we_o, wb_rd_o, wb_wdata_o}, 64'(0));
        chk("mid_rst_bus", {28'h0, be_o, addr_o}, 64'(0));
        step();
        rst = 1'b0;
        rvalid_i = 1'b1; rdata_i = 32'h1234_5678;
        step();
        rvalid_i = 1'b0; rdata_i = '0;
        @(negedge clk);
        chk("late_rvalid_wb", 64'(wb_valid_o), 64'(0));
        step();

        run_direct(EX_ADD, 32'h0, 32'h0, 32'h0000_0042, 5'd6, 1'b1,
                   '{we: 1'b1, rd: 5'd6, wdata: 32'h42, misalign: 1'b0, chk_data: 1'b1});

        repeat (4) step();
        chk("bus_scoreboard_drained", 64'(bus_q.size()), 64'(0));
        chk("wb_scoreboard_drained", 64'(wb_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
